// File: rtl/frame_sequencer.sv
// frame_sequencer
//
// Steps the test-pattern generator through every code enabled in
// PATTERN_MASK (ascending), lets the generator run FRAMES_PER_PATTERN
// frames per code, and enables the frame grabber for the last frame of
// each code only. Frame geometry (pixels per line, lines per frame) is
// checked against WIDTH/HEIGHT, and a missing frame after gen_start is
// reported as a timeout.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous, active-high reset
//   start        begin a sequence (honoured only while idle)
//   abort        stop the sequence at once, from any state
//   fval/lval/dval  frame / line / pixel strobes of the video bus
//   gen_start    one-cycle pulse: generator starts pattern `sel`
//   sel          current pattern code
//   en           grabber capture enable (one frame per pattern)
//   busy         high while a sequence is running
//   done         one-cycle pulse when the whole sequence has completed
//   geom_err     sticky: a line or frame had the wrong size
//   timeout_err  sticky: no frame arrived in time
//   frame_cnt    frames completed since the last start (wraps)

module frame_sequencer #(
    parameter int          WIDTH              = 640,
    parameter int          HEIGHT             = 480,
    parameter int          FRAMES_PER_PATTERN = 2,
    parameter logic [7:0]  PATTERN_MASK       = 8'b1100_1111,
    parameter int          TIMEOUT_CYCLES     = 2_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        fval,
    input  logic        lval,
    input  logic        dval,
    output logic        gen_start,
    output logic [2:0]  sel,
    output logic        en,
    output logic        busy,
    output logic        done,
    output logic        geom_err,
    output logic        timeout_err,
    output logic [15:0] frame_cnt
);

    function automatic logic [2:0] first_code(input logic [7:0] m);
        logic [2:0] c;
        c = '0;
        for (int k = 7; k >= 0; k--) begin
            if (m[k]) c = 3'(k);
        end
        return c;
    endfunction

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    localparam logic [2:0]  FIRST_SEL = first_code(PATTERN_MASK);
    localparam logic [7:0]  LAST_FRM  = 8'(FRAMES_PER_PATTERN - 1);
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [11:0] WIDTH_C   = 12'(WIDTH);
    localparam logic [11:0] HEIGHT_C  = 12'(HEIGHT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_F,
        S_FRAME,
        S_ADV
    } state_t;

    state_t      state;
    logic        fval_q;
    logic        lval_q;
    logic [7:0]  frm_idx;
    logic [31:0] tmo_cnt;
    logic [11:0] line_cnt;
    logic [11:0] pix_cnt;
    logic        in_line;

    logic        fval_rise;
    logic        fval_fall;
    logic        lval_rise;
    logic        lval_fall;
    logic        has_next;
    logic [2:0]  next_sel;

    assign fval_rise = fval & ~fval_q;
    assign fval_fall = ~fval & fval_q;
    assign lval_rise = lval & ~lval_q;
    assign lval_fall = ~lval & lval_q;

    // Next higher enabled code above the current one, if any.
    always_comb begin
        has_next = 1'b0;
        next_sel = sel;
        for (int k = 7; k >= 0; k--) begin
            if (PATTERN_MASK[k] && (k > int'(sel))) begin
                has_next = 1'b1;
                next_sel = 3'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            sel         <= FIRST_SEL;
            gen_start   <= 1'b0;
            en          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            geom_err    <= 1'b0;
            timeout_err <= 1'b0;
            frame_cnt   <= '0;
            fval_q      <= 1'b0;
            lval_q      <= 1'b0;
            frm_idx     <= '0;
            tmo_cnt     <= '0;
            line_cnt    <= '0;
            pix_cnt     <= '0;
            in_line     <= 1'b0;
        end else begin
            fval_q    <= fval;
            lval_q    <= lval;
            gen_start <= 1'b0;
            done      <= 1'b0;

            if (abort) begin
                // Error flags and frame_cnt are left as they are so the
                // aborted run can still be inspected.
                state   <= S_IDLE;
                sel     <= FIRST_SEL;
                en      <= 1'b0;
                busy    <= 1'b0;
                frm_idx <= '0;
                in_line <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        sel <= FIRST_SEL;
                        if (start) begin
                            state       <= S_LOAD;
                            busy        <= 1'b1;
                            frm_idx     <= '0;
                            frame_cnt   <= '0;
                            geom_err    <= 1'b0;
                            timeout_err <= 1'b0;
                        end
                    end

                    // sel was settled on entry here, so it is already
                    // stable for a full cycle when gen_start fires.
                    S_LOAD: begin
                        gen_start <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= S_WAIT_F;
                    end

                    S_WAIT_F: begin
                        if (fval_rise) begin
                            state    <= S_FRAME;
                            en       <= (frm_idx == LAST_FRM);
                            line_cnt <= lval_rise ? 12'd1 : 12'd0;
                            pix_cnt  <= (lval_rise && dval) ? 12'd1 : 12'd0;
                            in_line  <= lval_rise;
                        end else if (tmo_cnt >= TMO_LAST) begin
                            timeout_err <= 1'b1;
                            state       <= S_IDLE;
                            sel         <= FIRST_SEL;
                            busy        <= 1'b0;
                            frm_idx     <= '0;
                        end else begin
                            tmo_cnt <= tmo_cnt + 32'd1;
                        end
                    end

                    S_FRAME: begin
                        if (lval_rise) begin
                            line_cnt <= sat_inc(line_cnt);
                            pix_cnt  <= dval ? 12'd1 : 12'd0;
                            in_line  <= 1'b1;
                        end else if (lval && dval) begin
                            pix_cnt <= sat_inc(pix_cnt);
                        end
                        // Only lines that began inside this frame are judged.
                        if (lval_fall && in_line) begin
                            in_line <= 1'b0;
                            if (pix_cnt != WIDTH_C) geom_err <= 1'b1;
                        end
                        if (fval_fall) begin
                            if (line_cnt != HEIGHT_C) geom_err <= 1'b1;
                            frame_cnt <= frame_cnt + 16'd1;
                            in_line   <= 1'b0;
                            state     <= S_ADV;
                        end
                    end

                    S_ADV: begin
                        en <= 1'b0;
                        if (frm_idx < LAST_FRM) begin
                            // Generator free-runs: wait for its next frame.
                            frm_idx <= frm_idx + 8'd1;
                            tmo_cnt <= '0;
                            state   <= S_WAIT_F;
                        end else begin
                            frm_idx <= '0;
                            if (has_next) begin
                                sel   <= next_sel;
                                state <= S_LOAD;
                            end else begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                sel   <= FIRST_SEL;
                                state <= S_IDLE;
                            end
                        end
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Testbench for frame_sequencer: randomized-dval video frames, a reference
// model that expands the pattern mask into expected gen_start / capture /
// end-of-sequence events, and a negedge monitor that scores them.

module tb_frame_sequencer;

    localparam int         W    = 8;
    localparam int         H    = 4;
    localparam int         FPP  = 3;
    localparam int         TMO  = 100;
    localparam logic [7:0] MASK = 8'b1100_1111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        fval = 1'b0;
    logic        lval = 1'b0;
    logic        dval = 1'b0;
    logic        gen_start;
    logic [2:0]  sel;
    logic        en;
    logic        busy;
    logic        done;
    logic        geom_err;
    logic        timeout_err;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    frame_sequencer #(
        .WIDTH(W), .HEIGHT(H), .FRAMES_PER_PATTERN(FPP),
        .PATTERN_MASK(MASK), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .fval(fval), .lval(lval), .dval(dval),
        .gen_start(gen_start), .sel(sel), .en(en), .busy(busy),
        .done(done), .geom_err(geom_err), .timeout_err(timeout_err),
        .frame_cnt(frame_cnt)
    );

    typedef struct {
        logic [2:0] sel;
        int         fc_rise;
        int         fc_fall;
    } cap_t;

    typedef struct {
        logic done_v;
        int   fc;
        logic geom;
        logic tmo;
    } end_t;

    logic [2:0] gs_q[$];
    cap_t       cap_q[$];
    end_t       end_q[$];
    logic [2:0] codes[$];

    int n_checks = 0;
    int n_pass   = 0;
    int gs_seen  = 0;
    int done_seen = 0;
    int exp_done = 0;
    int cycle    = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic       busy_p = 1'b0;
    logic       en_p   = 1'b0;
    logic       tmo_p  = 1'b0;
    logic [2:0] sel_p  = 3'd0;
    int         gs_cyc = 0;
    cap_t       cur_cap;
    logic [2:0] e_sel;
    end_t       e_end;

    always @(negedge clk) begin
        cycle++;
        if (gen_start) begin
            gs_seen++;
            gs_cyc = cycle;
            if (gs_q.size() == 0) check("unexpected_gen_start", 1, 0);
            else begin
                e_sel = gs_q.pop_front();
                check("gs_sel", sel, e_sel);
                check("gs_sel_prev_cycle", sel_p, e_sel);
            end
        end
        if (en && !en_p) begin
            if (cap_q.size() == 0) check("unexpected_en", 1, 0);
            else begin
                cur_cap = cap_q.pop_front();
                check("cap_sel", sel, cur_cap.sel);
                check("cap_fc_rise", frame_cnt, cur_cap.fc_rise);
            end
        end
        if (!en && en_p) begin
            check("cap_sel_hold", sel_p, cur_cap.sel);
            check("cap_fc_fall", frame_cnt, cur_cap.fc_fall);
        end
        if (timeout_err && !tmo_p) check("tmo_latency", cycle - gs_cyc, TMO);
        if (done) done_seen++;
        if (!busy && busy_p) begin
            if (end_q.size() == 0) check("unexpected_end", 1, 0);
            else begin
                e_end = end_q.pop_front();
                check("end_done", done, e_end.done_v);
                check("end_frame_cnt", frame_cnt, e_end.fc);
                check("end_geom_err", geom_err, e_end.geom);
                check("end_timeout_err", timeout_err, e_end.tmo);
            end
        end
        busy_p = busy;
        en_p   = en;
        tmo_p  = timeout_err;
        sel_p  = sel;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gs(input int target);
        int n = 0;
        while (gs_seen < target && n < 300) begin
            cyc();
            n++;
        end
        check("gs_arrived", gs_seen >= target, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            cyc();
            n++;
        end
        check("idle_reached", busy, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // Full frame; line `long_line` carries one extra pixel.
    task automatic drive_frame(input int nlines, input int long_line);
        fval = 1'b1;
        cyc(); cyc();
        for (int l = 0; l < nlines; l++) begin
            int npix = W + ((l == long_line) ? 1 : 0);
            int got = 0;
            lval = 1'b1;
            while (got < npix) begin
                dval = ($urandom_range(3) != 0);
                if (dval) got++;
                cyc();
            end
            lval = 1'b0;
            dval = 1'b0;
            cyc(); cyc();
        end
        fval = 1'b0;
        cyc(); cyc(); cyc();
    endtask

    // Expected events for a complete sequence, then the stimulus for it.
    task automatic run_sequence(input int bad_h, input int bad_w, input bit poke_start);
        int   n = 0;
        logic g = 1'b0;
        int   base = gs_seen;
        foreach (codes[p]) begin
            gs_q.push_back(codes[p]);
            for (int f = 0; f < FPP; f++) begin
                if (n == bad_h || n == bad_w) g = 1'b1;
                n++;
                if (f == FPP - 1) cap_q.push_back('{codes[p], n - 1, n});
            end
        end
        end_q.push_back('{1'b1, n, g, 1'b0});
        exp_done++;

        start = 1'b1;
        cyc();
        start = 1'b0;
        check("gs_not_early", gen_start, 0);
        check("busy_after_start", busy, 1);
        cyc();
        check("gs_latency", gen_start, 1);

        n = 0;
        foreach (codes[p]) begin
            wait_gs(base + p + 1);
            cyc(); cyc();
            for (int f = 0; f < FPP; f++) begin
                if (bad_h >= 0 && n < bad_h) check("geom_clean", geom_err, 0);
                if (bad_h >= 0 && n == bad_h + 1) check("geom_sticky", geom_err, 1);
                drive_frame((n == bad_h) ? H - 1 : H, (n == bad_w) ? 1 : -1);
                if (poke_start && n == 1) pulse_start();
                n++;
            end
        end
        wait_idle();
        cyc(); cyc();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        for (int k = 0; k < 8; k++) if (MASK[k]) codes.push_back(3'(k));

        cyc();
        check("rst_busy", busy, 0);
        check("rst_en", en, 0);
        check("rst_gen_start", gen_start, 0);
        check("rst_done", done, 0);
        check("rst_geom_err", geom_err, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_sel", sel, codes[0]);
        rst = 1'b0;
        cyc(); cyc();

        // start together with abort: abort wins
        start = 1'b1;
        abort = 1'b1;
        cyc();
        start = 1'b0;
        abort = 1'b0;
        cyc(); cyc();
        check("start_abort_idle", busy, 0);

        // clean run, with a start pulse while busy
        run_sequence(-1, -1, 1'b1);

        // short frame 1, long line in frame 4
        run_sequence(1, 4, 1'b0);

        // timeout: no frame after gen_start
        base = gs_seen;
        gs_q.push_back(codes[0]);
        end_q.push_back('{1'b0, 0, 1'b0, 1'b1});
        pulse_start();
        wait_gs(base + 1);
        wait_idle();
        check("timeout_flag", timeout_err, 1);
        cyc(); cyc();

        // abort during the capture frame; geometry flag from frame 0 kept
        base = gs_seen;
        gs_q.push_back(codes[0]);
        cap_q.push_back('{codes[0], 2, 2});
        end_q.push_back('{1'b0, 2, 1'b1, 1'b0});
        pulse_start();
        wait_gs(base + 1);
        cyc(); cyc();
        drive_frame(H - 1, -1);
        drive_frame(H, -1);
        fval = 1'b1;
        cyc(); cyc();
        lval = 1'b1;
        dval = 1'b1;
        cyc(); cyc();
        check("en_capture", en, 1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("abort_en", en, 0);
        check("abort_busy", busy, 0);
        check("abort_geom_kept", geom_err, 1);
        lval = 1'b0;
        dval = 1'b0;
        fval = 1'b0;
        cyc(); cyc(); cyc();

        // restart after abort: flags cleared, starts from first code
        run_sequence(-1, -1, 1'b0);

        // asynchronous reset mid-line in the capture frame
        base = gs_seen;
        gs_q.push_back(codes[0]);
        cap_q.push_back('{codes[0], 2, 0});
        end_q.push_back('{1'b0, 0, 1'b0, 1'b0});
        pulse_start();
        wait_gs(base + 1);
        cyc(); cyc();
        drive_frame(H, -1);
        drive_frame(H, -1);
        fval = 1'b1;
        cyc(); cyc();
        lval = 1'b1;
        dval = 1'b1;
        cyc(); cyc();
        #1 rst = 1'b1;
        #1;
        check("arst_en", en, 0);
        check("arst_busy", busy, 0);
        check("arst_frame_cnt", frame_cnt, 0);
        check("arst_sel", sel, codes[0]);
        check("arst_gen_start", gen_start, 0);
        check("arst_flags", {geom_err, timeout_err, done}, 0);
        cyc();
        rst  = 1'b0;
        lval = 1'b0;
        dval = 1'b0;
        fval = 1'b0;
        cyc(); cyc(); cyc();

        run_sequence(-1, -1, 1'b0);

        cyc(); cyc(); cyc();
        check("gs_queue_drained", gs_q.size(), 0);
        check("cap_queue_drained", cap_q.size(), 0);
        check("end_queue_drained", end_q.size(), 0);
        check("done_pulses", done_seen, exp_done);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
